// File: rtl/miriscv_dmem_arb_pkg.sv
`default_nettype none
// miriscv_dmem_arb_pkg: types and round-robin helper for the data-memory arbiter.
// Rev 1.0
package miriscv_dmem_arb_pkg;
  localparam int XLEN      = miriscv_pkg::XLEN;
  localparam int MAX_PORTS = 8;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  // First set request at or above ptr, wrapping at n; returns a one-hot vector.
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                   input logic [2:0]           ptr,
                                                   input int unsigned          n);
    logic [MAX_PORTS-1:0] gnt;
    logic                 found;
    int unsigned          idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < n) begin
        idx = {29'd0, ptr} + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction
endpackage
`default_nettype wire

// File: rtl/miriscv_pkg.sv
`default_nettype none
// miriscv_pkg: core-wide constants shared by the data-path blocks.
// Rev 1.0
package miriscv_pkg;
  localparam int XLEN = 32;
endpackage
`default_nettype wire

// File: rtl/miriscv_rr_picker.sv
`default_nettype none
// miriscv_rr_picker: combinational round-robin search, one-hot and encoded winner.
// Rev 1.0
module miriscv_rr_picker
  import miriscv_dmem_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PTR_W-1:0]     idx,
  output logic                 any
);
  logic [MAX_PORTS-1:0] req_ext;
  logic [MAX_PORTS-1:0] gnt_ext;
  logic [2:0]           ptr_ext;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req;
    ptr_ext                  = '0;
    ptr_ext[PTR_W-1:0]       = ptr;
    gnt_ext                  = rr_pick(req_ext, ptr_ext, NUM_PORTS);
  end

  assign gnt = gnt_ext[NUM_PORTS-1:0];
  assign any = |gnt_ext;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) idx = PTR_W'(i);
    end
  end
endmodule
`default_nettype wire

// File: rtl/miriscv_dmem_arbiter.sv
`default_nettype none
// miriscv_dmem_arbiter: shares one data-memory port among NUM_PORTS masters,
// one transaction at a time, with round-robin grant and a hang watchdog. Rev 1.0
module miriscv_dmem_arbiter
  import miriscv_dmem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [NUM_PORTS-1:0]        m_req_i,
  input  logic [NUM_PORTS-1:0]        m_we_i,
  input  logic [NUM_PORTS*XLEN/8-1:0] m_be_i,
  input  logic [NUM_PORTS*XLEN-1:0]   m_addr_i,
  input  logic [NUM_PORTS*XLEN-1:0]   m_wdata_i,
  output logic [NUM_PORTS-1:0]        m_gnt_o,
  output logic [NUM_PORTS-1:0]        m_rvalid_o,
  output logic [NUM_PORTS-1:0]        m_err_o,
  output logic [XLEN-1:0]             m_rdata_o,
  output logic                        data_req_o,
  output logic                        data_we_o,
  output logic [XLEN/8-1:0]           data_be_o,
  output logic [XLEN-1:0]             data_addr_o,
  output logic [XLEN-1:0]             data_wdata_o,
  input  logic                        data_rvalid_i,
  input  logic [XLEN-1:0]             data_rdata_i,
  output logic                        busy_o
);
  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int BE_W  = XLEN / 8;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_MAX    = {WD_W{1'b1}};
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  arb_state_e           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     owner;
  logic                 aborted;
  logic [WD_W-1:0]      wd_cnt;
  logic                 lat_we;
  logic [BE_W-1:0]      lat_be;
  logic [XLEN-1:0]      lat_addr;
  logic [XLEN-1:0]      lat_wdata;

  logic [NUM_PORTS-1:0] pick_gnt;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [NUM_PORTS-1:0] owner_oh;
  logic                 in_wait;
  logic                 wd_expire;
  logic                 owner_req;
  logic [PTR_W-1:0]     next_ptr;
  logic                 sel_we;
  logic [BE_W-1:0]      sel_be;
  logic [XLEN-1:0]      sel_addr;
  logic [XLEN-1:0]      sel_wdata;

  miriscv_rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req (m_req_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        sel_we    = m_we_i[i];
        sel_be    = m_be_i[i*BE_W +: BE_W];
        sel_addr  = m_addr_i[i*XLEN +: XLEN];
        sel_wdata = m_wdata_i[i*XLEN +: XLEN];
      end
    end
  end

  assign in_wait   = (state == ARB_WAIT);
  assign owner_oh  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;
  assign owner_req = |(m_req_i & owner_oh);
  assign next_ptr  = (owner == LAST_PORT) ? '0 : owner + 1'b1;

  // A response in the expiry cycle takes precedence over the timeout.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      assign wd_expire = in_wait & ~data_rvalid_i & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_watchdog
      assign wd_expire = 1'b0;
    end
  endgenerate

  assign m_gnt_o      = (state == ARB_IDLE) ? pick_gnt : '0;
  assign m_rvalid_o   = (in_wait & data_rvalid_i & ~aborted) ? owner_oh : '0;
  assign m_err_o      = (wd_expire & ~aborted) ? owner_oh : '0;
  assign m_rdata_o    = data_rdata_i;
  assign data_req_o   = in_wait & ~aborted & ~data_rvalid_i;
  assign data_we_o    = in_wait & lat_we;
  assign data_be_o    = in_wait ? lat_be : '0;
  assign data_addr_o  = in_wait ? lat_addr : '0;
  assign data_wdata_o = in_wait ? lat_wdata : '0;
  assign busy_o       = in_wait;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      aborted   <= 1'b0;
      wd_cnt    <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state     <= ARB_WAIT;
            owner     <= pick_idx;
            lat_we    <= sel_we;
            lat_be    <= sel_be;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            wd_cnt    <= '0;
            aborted   <= 1'b0;
          end
        end
        ARB_WAIT: begin
          if (data_rvalid_i || wd_expire) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_ptr;
          end else begin
            // Stay put after an abort: the memory may still answer.
            if (!owner_req) aborted <= 1'b1;
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_miriscv_dmem_arbiter.sv
`default_nettype none
// tb_miriscv_dmem_arbiter: directed self-checking bench, two ports, 4-cycle watchdog.
// Rev 1.0
module tb_miriscv_dmem_arbiter;
  logic        clk = 1'b0;
  logic        arstn = 1'b1;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [7:0]  m_be = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_err;
  logic [31:0] m_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int exp_port;

  miriscv_dmem_arbiter #(
    .NUM_PORTS      (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .m_req_i       (m_req),
    .m_we_i        (m_we),
    .m_be_i        (m_be),
    .m_addr_i      (m_addr),
    .m_wdata_i     (m_wdata),
    .m_gnt_o       (m_gnt),
    .m_rvalid_o    (m_rvalid),
    .m_err_o       (m_err),
    .m_rdata_o     (m_rdata),
    .data_req_o    (data_req),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .data_rvalid_i (data_rvalid),
    .data_rdata_i  (data_rdata),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    // reset, asserted away from any edge
    #1 arstn = 1'b0;
    #1;
    chk("rst_busy",   64'(busy), 64'h0);
    chk("rst_req",    64'(data_req), 64'h0);
    chk("rst_addr",   64'(data_addr), 64'h0);
    chk("rst_gnt",    64'(m_gnt), 64'h0);
    chk("rst_rvalid", 64'(m_rvalid), 64'h0);
    chk("rst_err",    64'(m_err), 64'h0);
    tick();
    tick();
    arstn = 1'b1;

    // single load on port 0
    m_req = 2'b01; m_addr[31:0] = 32'h100; m_we[0] = 1'b0; m_be[3:0] = 4'hF;
    look();
    chk("t1_gnt",   64'(m_gnt), 64'h1);
    chk("t1_busy0", 64'(busy), 64'h0);
    tick(); look();
    chk("t1_req1",  64'(data_req), 64'h1);
    chk("t1_addr",  64'(data_addr), 64'h100);
    chk("t1_we",    64'(data_we), 64'h0);
    chk("t1_gnt1",  64'(m_gnt), 64'h0);
    tick(); look();
    chk("t1_req2",  64'(data_req), 64'h1);
    tick();
    data_rvalid = 1'b1; data_rdata = 32'hDEADBEEF;
    look();
    chk("t1_req3",   64'(data_req), 64'h0);
    chk("t1_rvalid", 64'(m_rvalid), 64'h1);
    chk("t1_rdata",  64'(m_rdata), 64'hDEADBEEF);
    tick();
    data_rvalid = 1'b0; m_req = 2'b00;
    look();
    chk("t1_idle",    64'(busy), 64'h0);
    chk("t1_rvalid0", 64'(m_rvalid), 64'h0);
    tick();

    // contention: pointer sits at 1 after port 0 was served
    m_req = 2'b11; m_we = 2'b11;
    m_addr = {32'h300, 32'h200}; m_wdata = {32'h22222222, 32'h11111111};
    exp_port = 1;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("t2_gnt", 64'(m_gnt), 64'(1 << exp_port));
      tick();
      data_rvalid = 1'b1;
      look();
      chk("t2_addr",   64'(data_addr), (exp_port == 1) ? 64'h300 : 64'h200);
      chk("t2_wdata",  64'(data_wdata), (exp_port == 1) ? 64'h22222222 : 64'h11111111);
      chk("t2_rvalid", 64'(m_rvalid), 64'(1 << exp_port));
      tick();
      data_rvalid = 1'b0;
      exp_port = 1 - exp_port;
    end

    // store on port 1, payload disturbed after grant
    m_req = 2'b10; m_we = 2'b10; m_be[7:4] = 4'b0100;
    m_addr[63:32] = 32'h400; m_wdata[63:32] = 32'h00AA0000;
    look();
    chk("t3_gnt", 64'(m_gnt), 64'h2);
    tick();
    m_addr[63:32] = 32'h999; m_wdata[63:32] = 32'hFFFFFFFF; m_be[7:4] = 4'hF; m_we[1] = 1'b0;
    look();
    chk("t3_req",   64'(data_req), 64'h1);
    chk("t3_we",    64'(data_we), 64'h1);
    chk("t3_be",    64'(data_be), 64'h4);
    chk("t3_addr",  64'(data_addr), 64'h400);
    chk("t3_wdata", 64'(data_wdata), 64'h00AA0000);
    tick(); look();
    chk("t3_addr2", 64'(data_addr), 64'h400);
    tick();
    data_rvalid = 1'b1;
    look();
    chk("t3_rvalid", 64'(m_rvalid), 64'h2);
    chk("t3_be2",    64'(data_be), 64'h4);
    tick();
    data_rvalid = 1'b0; m_req = 2'b00;

    // abort: port 0 drops its request one cycle after grant
    m_req = 2'b11; m_addr = {32'h600, 32'h500}; m_we = 2'b00;
    look();
    chk("t4_gnt", 64'(m_gnt), 64'h1);
    tick();
    m_req = 2'b10;
    look();
    chk("t4_req_still", 64'(data_req), 64'h1);
    tick(); look();
    chk("t4_req_drop", 64'(data_req), 64'h0);
    chk("t4_busy",     64'(busy), 64'h1);
    chk("t4_nogrant",  64'(m_gnt), 64'h0);
    tick();
    data_rvalid = 1'b1; data_rdata = 32'h12345678;
    look();
    chk("t4_discard",   64'(m_rvalid), 64'h0);
    chk("t4_nogrant2",  64'(m_gnt), 64'h0);
    tick();
    data_rvalid = 1'b0;
    look();
    chk("t4_gnt1", 64'(m_gnt), 64'h2);
    tick();
    data_rvalid = 1'b1;
    look();
    chk("t4_rvalid1", 64'(m_rvalid), 64'h2);
    chk("t4_addr1",   64'(data_addr), 64'h600);
    tick();
    data_rvalid = 1'b0; m_req = 2'b00;

    // watchdog: expires in the 4th WAIT cycle
    m_req = 2'b01;
    look();
    chk("t5_gnt", 64'(m_gnt), 64'h1);
    tick();
    for (int w = 0; w < 3; w++) begin
      look();
      chk("t5_noerr", 64'(m_err), 64'h0);
      chk("t5_req",   64'(data_req), 64'h1);
      tick();
    end
    look();
    chk("t5_err",     64'(m_err), 64'h1);
    chk("t5_rvalid0", 64'(m_rvalid), 64'h0);
    tick();
    m_req = 2'b11;
    look();
    chk("t5_idle",  64'(busy), 64'h0);
    chk("t5_ptr",   64'(m_gnt), 64'h2);
    tick();
    for (int w = 0; w < 3; w++) begin
      look();
      chk("t5_noerr2", 64'(m_err), 64'h0);
      tick();
    end
    data_rvalid = 1'b1;
    look();
    chk("t5_rv_wins", 64'(m_rvalid), 64'h2);
    chk("t5_err_sup", 64'(m_err), 64'h0);
    tick();
    data_rvalid = 1'b0; m_req = 2'b00;

    // asynchronous reset in mid-WAIT, then a late response
    m_req = 2'b01;
    look();
    chk("t6_gnt", 64'(m_gnt), 64'h1);
    tick(); look();
    chk("t6_busy", 64'(busy), 64'h1);
    arstn = 1'b0; m_req = 2'b00;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_req",  64'(data_req), 64'h0);
    chk("t6_rst_addr", 64'(data_addr), 64'h0);
    chk("t6_rst_gnt",  64'(m_gnt), 64'h0);
    tick();
    arstn = 1'b1; data_rvalid = 1'b1; data_rdata = 32'hCAFEF00D;
    look();
    chk("t6_late_rv", 64'(m_rvalid), 64'h0);
    chk("t6_idle",    64'(busy), 64'h0);
    tick();
    data_rvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
